// File: rtl/cook_timer_ctrl.sv
// rtl/cook_timer_ctrl.sv - cook timer driving magnetron latch S/R pulses, seconds countdown.
// Optional door-pause/resume behaviour is enabled by defining PAUSE_RESUME_EN.
module cook_timer_ctrl #(
  parameter int TICKS_PER_SEC = 100,
  parameter int TIME_W        = 7
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              stop,
  input  logic              door_closed,
  input  logic              load,
  input  logic [TIME_W-1:0] load_val,
  output logic              set_p,
  output logic              rst_p,
  output logic [TIME_W-1:0] time_left,
  output logic              cooking,
  output logic              done
);

  localparam int PW = (TICKS_PER_SEC > 2) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [PW-1:0] PS_LAST = PW'(TICKS_PER_SEC - 1);

  typedef enum logic [1:0] {IDLE, COOK, PAUSE, DONE} state_t;

  state_t             state, state_nx;
  logic [PW-1:0]      ps, ps_nx;
  logic [TIME_W-1:0]  tl_nx;
  logic               start_q;
  logic               start_edge;
  logic               set_nx, rst_nx;

  assign start_edge = start & ~start_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ps        <= '0;
      time_left <= '0;
      start_q   <= 1'b0;
      set_p     <= 1'b0;
      rst_p     <= 1'b0;
      cooking   <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_nx;
      ps        <= ps_nx;
      time_left <= tl_nx;
      start_q   <= start;
      set_p     <= set_nx;
      rst_p     <= rst_nx;
      cooking   <= (state_nx == COOK);
      done      <= (state_nx == DONE);
    end
  end

  always_comb begin
    state_nx = state;
    ps_nx    = ps;
    tl_nx    = time_left;
    set_nx   = 1'b0;
    rst_nx   = 1'b0;
    case (state)
      IDLE: begin
        if (stop) begin
          tl_nx = '0;
        end else if (start_edge && door_closed && (time_left != '0)) begin
          state_nx = COOK;
          ps_nx    = '0;
          set_nx   = 1'b1;
        end else if (load) begin
          tl_nx = load_val;
        end
      end
      COOK: begin
        if (stop) begin
          state_nx = IDLE;
          tl_nx    = '0;
          rst_nx   = 1'b1;
        end else if (!door_closed) begin
          // Door takes precedence over an expiry landing in the same cycle.
          rst_nx = 1'b1;
`ifdef PAUSE_RESUME_EN
          state_nx = PAUSE;
`else
          state_nx = IDLE;
          tl_nx    = '0;
`endif
        end else if (ps == PS_LAST) begin
          ps_nx = '0;
          if (time_left <= TIME_W'(1)) begin
            tl_nx    = '0;
            state_nx = DONE;
            rst_nx   = 1'b1;
          end else begin
            tl_nx = time_left - 1'b1;
          end
        end else begin
          ps_nx = ps + 1'b1;
        end
      end
      PAUSE: begin
        if (stop) begin
          state_nx = IDLE;
          tl_nx    = '0;
        end else if (start_edge && door_closed) begin
          state_nx = COOK;
          ps_nx    = '0;
          set_nx   = 1'b1;
        end
      end
      DONE: begin
        if (stop) begin
          state_nx = IDLE;
        end else if (load) begin
          state_nx = IDLE;
          tl_nx    = load_val;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule
